uart_rx_frame: RTL and testbench

Parametrised UART receiver for the serial front-end, the next generation of the fixed 8N1 receiver. Supports configurable data width, 1 or 2 stop bits and optional even/odd parity. Adds input synchronisation, false-start rejection, framing and break detection, and a one-word holding register with a valid/ready handshake and overrun reporting. Driven by the shared oversampling baud tick generator. Feeds the command decoder.

---
 rtl/uart_rx_frame.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: configurable width/stop bits, false-start, framing and break
// detection, one-word holding register with valid/ready handshake. Optional parity via UART_RX_PARITY_EN.
module uart_rx_frame #(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic            rd_ready,
  output logic [DBIT-1:0] dout,
  output logic            dout_valid,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun,
  output logic            break_det,
  output logic            busy
);

  localparam int SW = $clog2(SB_TICK);
  localparam logic [SW-1:0] S_ZERO  = {SW{1'b0}};
  localparam logic [SW-1:0] S_ONE   = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] S_LAST  = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_MID   = SW'(SB_TICK / 2 - 1);
  localparam logic [3:0]    N_DLAST = 4'(DBIT - 1);
  localparam logic [3:0]    N_SLAST = 4'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 2);
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_BRK_WAIT} state_t;
  logic pbit_r, pbit_n, perr_r, perr_n;
`else
  // Parity hardware is not built; PARITY is accepted only so instantiations stay portable.
  localparam logic PERR_TIE = 1'b0 & (PARITY != 0);
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BRK_WAIT} state_t;
`endif

  function automatic logic even_parity(input logic [DBIT-1:0] v);
    return ^v;
  endfunction

  state_t            state_r, state_n;
  logic              sync1_r, rxs_r;
  logic [SW-1:0]     s_r, s_n;
  logic [3:0]        n_r, n_n;
  logic [DBIT-1:0]   b_r, b_n;
  logic              ferr_r, ferr_n;
  logic [DBIT-1:0]   dout_r, dout_n;
  logic              dout_valid_r, dout_valid_n;
  logic              parity_err_r, parity_err_n;
  logic              frame_err_r, frame_err_n;
  logic              overrun_r, overrun_n;
  logic              break_det_r, break_det_n;
  logic              busy_r, busy_n;
  logic              done_s, brk_s, zero_s;

  // Two-flop synchroniser for the asynchronous serial line (idles high)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
    end else begin
      sync1_r <= rx;
      rxs_r   <= sync1_r;
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      s_r          <= S_ZERO;
      n_r          <= 4'd0;
      b_r          <= {DBIT{1'b0}};
      ferr_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit_r       <= 1'b0;
      perr_r       <= 1'b0;
`endif
      dout_r       <= {DBIT{1'b0}};
      dout_valid_r <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      break_det_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      s_r          <= s_n;
      n_r          <= n_n;
      b_r          <= b_n;
      ferr_r       <= ferr_n;
`ifdef UART_RX_PARITY_EN
      pbit_r       <= pbit_n;
      perr_r       <= perr_n;
`endif
      dout_r       <= dout_n;
      dout_valid_r <= dout_valid_n;
      parity_err_r <= parity_err_n;
      frame_err_r  <= frame_err_n;
      overrun_r    <= overrun_n;
      break_det_r  <= break_det_n;
      busy_r       <= busy_n;
    end
  end

  // Next-state, counter and holding-register logic
  always_comb begin
    state_n      = state_r;
    s_n          = s_r;
    n_n          = n_r;
    b_n          = b_r;
    ferr_n       = ferr_r;
`ifdef UART_RX_PARITY_EN
    pbit_n       = pbit_r;
    perr_n       = perr_r;
`endif
    dout_n       = dout_r;
    parity_err_n = parity_err_r;
    frame_err_n  = frame_err_r;
    overrun_n    = 1'b0;
    break_det_n  = 1'b0;
    done_s       = 1'b0;
    brk_s        = 1'b0;
    zero_s       = (b_r == {DBIT{1'b0}});

    if (rd_ready && dout_valid_r) dout_valid_n = 1'b0;
    else                          dout_valid_n = dout_valid_r;

    case (state_r)
      ST_IDLE: begin
        if (!rxs_r) begin
          s_n     = S_ZERO;
          state_n = ST_START;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (s_tick && (s_r == S_MID)) begin
          if (rxs_r) begin
            state_n = ST_IDLE;
          end else begin
            s_n     = S_ZERO;
            n_n     = 4'd0;
            ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit_n  = 1'b0;
            perr_n  = 1'b0;
`endif
            state_n = ST_DATA;
          end
        end else if (s_tick) begin
          s_n = s_r + S_ONE;
        end else begin
          s_n = s_r;
        end
      end
      ST_DATA: begin
        if (s_tick && (s_r == S_LAST)) begin
          s_n = S_ZERO;
          b_n = {rxs_r, b_r[DBIT-1:1]};
          if (n_r == N_DLAST) begin
            n_n = 4'd0;
`ifdef UART_RX_PARITY_EN
            if (PAR_EN) state_n = ST_PAR;
            else        state_n = ST_STOP;
`else
            state_n = ST_STOP;
`endif
          end else begin
            n_n = n_r + 4'd1;
          end
        end else if (s_tick) begin
          s_n = s_r + S_ONE;
        end else begin
          s_n = s_r;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PAR: begin
        if (s_tick && (s_r == S_LAST)) begin
          s_n     = S_ZERO;
          pbit_n  = rxs_r;
          perr_n  = rxs_r ^ even_parity(b_r) ^ PAR_ODD;
          state_n = ST_STOP;
        end else if (s_tick) begin
          s_n = s_r + S_ONE;
        end else begin
          s_n = s_r;
        end
      end
`endif
      ST_STOP: begin
        if (s_tick && (s_r == S_LAST)) begin
          s_n    = S_ZERO;
          ferr_n = ferr_r | ~rxs_r;
          if (n_r == N_SLAST) done_s = 1'b1;
          else                n_n    = n_r + 4'd1;
        end else if (s_tick) begin
          s_n = s_r + S_ONE;
        end else begin
          s_n = s_r;
        end
      end
      ST_BRK_WAIT: begin
        if (rxs_r) state_n = ST_IDLE;
        else       state_n = ST_BRK_WAIT;
      end
      default: state_n = ST_IDLE;
    endcase

    // A frame of all zeros with a bad stop is a line break, not data
    if (done_s) begin
`ifdef UART_RX_PARITY_EN
      brk_s = zero_s && !pbit_r && ferr_n;
`else
      brk_s = zero_s && ferr_n;
`endif
      if (brk_s) begin
        break_det_n = 1'b1;
        state_n     = ST_BRK_WAIT;
      end else begin
        dout_n       = b_r;
`ifdef UART_RX_PARITY_EN
        parity_err_n = perr_r;
`else
        parity_err_n = 1'b0;
`endif
        frame_err_n  = ferr_n;
        overrun_n    = dout_valid_r && !rd_ready;
        dout_valid_n = 1'b1;
        state_n      = ST_IDLE;
      end
    end else begin
      brk_s = 1'b0;
    end

    busy_n = (state_n != ST_IDLE);
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`else
  assign parity_err = PERR_TIE | (parity_err_r & 1'b0);
`endif
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign break_det  = break_det_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed table, hand sequences (false start, overrun,
// break, two stop bits, mid-frame reset) and randomized frames against a frame-level model.
module tb_uart_rx_frame;

  localparam int BIT = 64;  // 16 s_tick x 4 clk
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_CLK = (10 + PB) * BIT;

  logic       clk, reset, rx, s_tick, rd_ready, rd_ready2;
  logic [7:0] dout, dout2;
  logic       dout_valid, parity_err, frame_err, overrun, break_det, busy;
  logic       dout_valid2, parity_err2, frame_err2, overrun2, break_det2, busy2;

  int n_pass = 0, n_checks = 0;
  int ovr_cnt = 0, brk_cnt = 0;

  uart_rx_frame #(.DBIT(8), .SB_TICK(16), .STOP_BITS(1), .PARITY(PB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick), .rd_ready(rd_ready),
    .dout(dout), .dout_valid(dout_valid), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .break_det(break_det), .busy(busy));

  uart_rx_frame #(.DBIT(8), .SB_TICK(16), .STOP_BITS(2), .PARITY(0)) dut2 (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick), .rd_ready(rd_ready2),
    .dout(dout2), .dout_valid(dout_valid2), .parity_err(parity_err2), .frame_err(frame_err2),
    .overrun(overrun2), .break_det(break_det2), .busy(busy2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  // Count one-clk pulses of the main receiver
  always @(negedge clk) begin
    if (overrun)   ovr_cnt <= ovr_cnt + 1;
    if (break_det) brk_cnt <= brk_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic bitx(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // A 0 stop bit is shortened so the receiver's re-arm sees idle well before mid-bit.
  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop1_ok,
                            input logic stop2_ok, input int nstop, input bit with_par);
    logic ok;
    bitx(1'b0, BIT);
    for (int i = 0; i < 8; i++) bitx(d[i], BIT);
    if (with_par) bitx((^d) ^ pflip, BIT);
    for (int s = 0; s < nstop; s++) begin
      ok = (s == 0) ? stop1_ok : stop2_ok;
      if (ok) bitx(1'b1, BIT);
      else begin
        bitx(1'b0, 40);
        bitx(1'b1, 24);
      end
    end
    bitx(1'b1, 96);
  endtask

  task automatic rd();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pflip;
    logic       stop_ok;
    logic [7:0] exp_dout;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vt[5];
  logic [7:0] d, md;
  logic       pf, sok, pbit, mvalid, mperr, mferr, brk;
  int         exp_ovr, exp_brk;

  initial begin
    vt[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[2] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    vt[3] = '{8'h03, 1'b1, 1'b1, 8'h03, logic'(PB != 0), 1'b0};
    vt[4] = '{8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};

    rx = 1'b1; rd_ready = 1'b0; rd_ready2 = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 8'h00);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_brk", break_det, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_busy2", busy2, 1'b0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Start latency and a 5-tick glitch rejected as a false start
    rx = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_before_start", busy, 1'b0);
    @(negedge clk);
    chk("busy_at_start", busy, 1'b1);
    repeat (17) @(negedge clk);
    rx = 1'b1;
    repeat (25) @(negedge clk);
    chk("false_start_busy", busy, 1'b0);
    chk("false_start_valid", dout_valid, 1'b0);
    repeat (100) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      send_frame(vt[i].data, vt[i].pflip, vt[i].stop_ok, 1'b1, 1, PB != 0);
      chk($sformatf("tbl%0d_dout", i), dout, vt[i].exp_dout);
      chk($sformatf("tbl%0d_valid", i), dout_valid, 1'b1);
      chk($sformatf("tbl%0d_perr", i), parity_err, vt[i].exp_perr);
      chk($sformatf("tbl%0d_ferr", i), frame_err, vt[i].exp_ferr);
      rd();
      chk($sformatf("tbl%0d_valid_after_rd", i), dout_valid, 1'b0);
    end

    // Two unread frames: one overrun, newest word held
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1, PB != 0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1, PB != 0);
    chk("ovr_count", ovr_cnt, 1);
    chk("ovr_dout", dout, 8'h22);
    chk("ovr_valid", dout_valid, 1'b1);
    rd();

    // Line break for two frame times, then a normal frame
    bitx(1'b0, 2 * FRAME_CLK);
    bitx(1'b1, 128);
    chk("brk_count", brk_cnt, 1);
    chk("brk_valid", dout_valid, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1, PB != 0);
    chk("post_brk_dout", dout, 8'h5A);
    chk("post_brk_valid", dout_valid, 1'b1);
    chk("post_brk_perr", parity_err, 1'b0);
    chk("post_brk_ferr", frame_err, 1'b0);
    rd();

    // Randomized frames against a frame-level model of the holding register
    exp_ovr = 1; exp_brk = 1; mvalid = 1'b0; md = 8'h00; mperr = 1'b0; mferr = 1'b0;
    for (int k = 0; k < 24; k++) begin
      d   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) d = 8'h00;
      pf  = (PB != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      sok = ($urandom_range(0, 3) != 0);
      send_frame(d, pf, sok, 1'b1, 1, PB != 0);
      pbit = (^d) ^ pf;
      brk  = (d == 8'h00) && ((PB == 0) || (pbit == 1'b0)) && !sok;
      if (brk) exp_brk++;
      else begin
        if (mvalid) exp_ovr++;
        mvalid = 1'b1;
        md     = d;
        mperr  = (PB != 0) && ((($countones(d) + int'(pbit)) % 2) == 1);
        mferr  = !sok;
      end
      chk($sformatf("rnd%0d_valid", k), dout_valid, mvalid);
      if (mvalid) begin
        chk($sformatf("rnd%0d_dout", k), dout, md);
        chk($sformatf("rnd%0d_perr", k), parity_err, mperr);
        chk($sformatf("rnd%0d_ferr", k), frame_err, mferr);
      end
      chk($sformatf("rnd%0d_ovr", k), ovr_cnt, exp_ovr);
      chk($sformatf("rnd%0d_brk", k), brk_cnt, exp_brk);
      if ($urandom_range(0, 1) == 1) begin
        rd();
        mvalid = 1'b0;
      end
    end

    // Two stop bits, second one low: framing error on the 2-stop receiver
    bitx(1'b1, 128);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b0, 2, 1'b0);
    chk("sb2_dout", dout2, 8'h7E);
    chk("sb2_valid", dout_valid2, 1'b1);
    chk("sb2_ferr", frame_err2, 1'b1);
    chk("sb2_perr", parity_err2, 1'b0);

    // Reset in the middle of the data bits of the next frame
    bitx(1'b0, BIT);
    bitx(1'b1, BIT);
    bitx(1'b0, BIT);
    bitx(1'b1, 32);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_dout", dout, 8'h00);
    chk("mid_rst_valid", dout_valid, 1'b0);
    chk("mid_rst_perr", parity_err, 1'b0);
    chk("mid_rst_ferr", frame_err, 1'b0);
    chk("mid_rst_ovr", overrun, 1'b0);
    chk("mid_rst_brk", break_det, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_dout2", dout2, 8'h00);
    chk("mid_rst_valid2", dout_valid2, 1'b0);
    chk("mid_rst_ferr2", frame_err2, 1'b0);
    chk("mid_rst_busy2", busy2, 1'b0);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    reset = 1'b0;
    repeat (800) @(negedge clk);
    chk("post_rst_valid", dout_valid, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_valid2", dout_valid2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
